// File: rtl/sra_pkg.sv
// sra_pkg: shared state encoding, AU op codes and ctrl_word bit positions for the SRA controller.
package sra_pkg;
    localparam int CW_W = 20;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD  = 4'd1,
        S_ABS_A = 4'd2,
        S_ABS_B = 4'd3,
        S_MIN   = 4'd4,
        S_MAX   = 4'd5,
        S_SUB   = 4'd6,
        S_ADD   = 4'd7,
        S_MAXF  = 4'd8,
        S_DONE  = 4'd9
    } state_t;

    localparam logic [1:0] AU1_ABS_B  = 2'b00;
    localparam logic [1:0] AU1_MIN    = 2'b01;
    localparam logic [1:0] AU1_MAX    = 2'b10;
    localparam logic [1:0] AU1_PASS_A = 2'b11;

    localparam logic [1:0] AU2_ADD    = 2'b00;
    localparam logic [1:0] AU2_SUB    = 2'b01;
    localparam logic [1:0] AU2_MAX    = 2'b10;
    localparam logic [1:0] AU2_PASS_A = 2'b11;

    localparam int B_W_R1    = 19;
    localparam int B_W_R2    = 18;
    localparam int B_W_R3    = 17;
    localparam int B_W_R4    = 16;
    localparam int B_W_R5    = 15;
    localparam int B_S0_R1   = 14;
    localparam int B_S1_R1   = 13;
    localparam int B_S0_R2   = 12;
    localparam int B_S1_R2   = 11;
    localparam int B_S0_BAU1 = 10;
    localparam int B_S1_BAU1 = 9;
    localparam int B_S0_R5   = 8;
    localparam int B_S1_R5   = 7;
    localparam int B_S0_AAU2 = 6;
    localparam int B_S1_AAU2 = 5;
    localparam int B_AU1     = 3;
    localparam int B_AU2     = 1;
    localparam int B_OE      = 0;

    function automatic logic [CW_W-1:0] bit_of(input int p);
        return CW_W'(1) << p;
    endfunction

    function automatic logic [CW_W-1:0] au1_of(input logic [1:0] op);
        return CW_W'(op) << B_AU1;
    endfunction

    function automatic logic [CW_W-1:0] au2_of(input logic [1:0] op);
        return CW_W'(op) << B_AU2;
    endfunction
endpackage

// File: rtl/sra_ctrl_decode.sv
// sra_ctrl_decode: combinational state-to-ctrl_word decoder for the SRA microsequence.
module sra_ctrl_decode
    import sra_pkg::*;
(
    input  state_t            i_state,
    output logic [CW_W-1:0]   o_ctrl_word
);
    always_comb begin
        o_ctrl_word = '0;
        case (i_state)
            S_LOAD:  o_ctrl_word = bit_of(B_W_R1) | bit_of(B_W_R2) | bit_of(B_S0_R1) | bit_of(B_S0_R2);
            S_ABS_A: o_ctrl_word = bit_of(B_S0_BAU1) | au1_of(AU1_ABS_B) | bit_of(B_S1_R1) | bit_of(B_W_R1);
            S_ABS_B: o_ctrl_word = bit_of(B_S1_BAU1) | au1_of(AU1_ABS_B) | bit_of(B_S1_R2) | bit_of(B_W_R2);
            S_MIN:   o_ctrl_word = bit_of(B_S1_BAU1) | au1_of(AU1_MIN) | bit_of(B_W_R3);
            S_MAX:   o_ctrl_word = bit_of(B_S1_BAU1) | au1_of(AU1_MAX) | bit_of(B_W_R4) |
                                   bit_of(B_S0_R5) | bit_of(B_W_R5);
            S_SUB:   o_ctrl_word = bit_of(B_S0_AAU2) | au2_of(AU2_SUB) | bit_of(B_S1_R5) | bit_of(B_W_R5);
            S_ADD:   o_ctrl_word = bit_of(B_S1_AAU2) | au2_of(AU2_ADD) | bit_of(B_S1_R5) | bit_of(B_W_R5);
            S_MAXF:  o_ctrl_word = bit_of(B_S0_AAU2) | au2_of(AU2_MAX) | bit_of(B_S1_R5) | bit_of(B_W_R5);
            S_DONE:  o_ctrl_word = bit_of(B_OE);
            default: o_ctrl_word = '0;
        endcase
    end
endmodule

// File: rtl/sra_controller.sv
// sra_controller: nine-step sequencing FSM driving the SRA datapath control word.
// Define SRA_CTRL_HOLD_EN to hold DONE until ack; otherwise DONE lasts one cycle.
module sra_controller
    import sra_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            ack,
    output logic [CW_W-1:0] ctrl_word,
    output logic            ready,
    output logic            busy,
    output logic            done
);
    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_ABS_A;
            S_ABS_A: w_next = S_ABS_B;
            S_ABS_B: w_next = S_MIN;
            S_MIN:   w_next = S_MAX;
            S_MAX:   w_next = S_SUB;
            S_SUB:   w_next = S_ADD;
            S_ADD:   w_next = S_MAXF;
            S_MAXF:  w_next = S_DONE;
`ifdef SRA_CTRL_HOLD_EN
            S_DONE:  w_next = ack ? S_IDLE : S_DONE;
`else
            S_DONE:  w_next = S_IDLE;
`endif
            default: w_next = S_IDLE;
        endcase
    end

`ifndef SRA_CTRL_HOLD_EN
    logic w_unused_ack;
    assign w_unused_ack = ack;
`endif

    sra_ctrl_decode u_decode (
        .i_state     (r_state),
        .o_ctrl_word (ctrl_word)
    );

    assign ready = (r_state == S_IDLE);
    assign busy  = (r_state >= S_LOAD) && (r_state <= S_MAXF);
    assign done  = (r_state == S_DONE);
endmodule
